// File: rtl/alu_iterative.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative shift-add MUL and restoring DIV.
// Ports: clk/rst; in_valid/in_ready + IN1/IN2/Operation request; out_valid/out_ready + OUT/OUT_HI/Status/Error result.
// Latency 1 for single-cycle ops and DIV-by-zero, WIDTH+1 for MUL/DIV; result held while out_ready=0.
module alu_iterative #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  input  logic [3:0]       Operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] OUT_HI,
  output logic             Status,
  output logic             Error
);

  localparam logic [3:0] OP_AND = 4'd0, OP_OR  = 4'd1, OP_ADD = 4'd2, OP_MUL = 4'd3,
                         OP_DIV = 4'd4, OP_NOT = 4'd5, OP_SUB = 4'd6, OP_RS  = 4'd7,
                         OP_LS  = 4'd8;
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nx;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_q, lo_q;   // MUL: {partial high, multiplier/low}; DIV: {remainder, dividend/quotient}
  logic [SHW-1:0]   cnt;

  logic             accept;
  logic             iterative;
  logic [WIDTH-1:0] sc_lo, sc_hi;
  logic             sc_err;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH:0]   sum, shifted, trial;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  // DIV by zero short-circuits to the single-cycle path.
  assign iterative = (Operation == OP_MUL) || ((Operation == OP_DIV) && (IN2 != '0));

  // Single-cycle results, computed from the live inputs at the accept edge.
  always_comb begin
    sc_lo  = '0;
    sc_hi  = '0;
    sc_err = 1'b0;
    case (Operation)
      OP_AND: sc_lo = IN1 & IN2;
      OP_OR:  sc_lo = IN1 | IN2;
      OP_ADD: sc_lo = IN1 + IN2;
      OP_NOT: sc_lo = ~IN1;
      OP_SUB: sc_lo = IN1 - IN2;
      OP_RS:  sc_lo = IN1 >> IN2[SHW-1:0];
      OP_LS:  sc_lo = IN1 << IN2[SHW-1:0];
      OP_MUL: sc_lo = '0;
      OP_DIV: begin
        sc_lo  = '1;
        sc_hi  = IN1;
        sc_err = 1'b1;
      end
      default: sc_err = 1'b1;
    endcase
  end

  // One iteration step of shift-add multiply or restoring divide.
  always_comb begin
    step_hi = hi_q;
    step_lo = lo_q;
    sum     = '0;
    shifted = '0;
    trial   = '0;
    if (op_q == OP_MUL) begin
      sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      step_hi = sum[WIDTH:1];
      step_lo = {sum[0], lo_q[WIDTH-1:1]};
    end else begin
      shifted = {hi_q, lo_q[WIDTH-1]};
      trial   = shifted - {1'b0, b_q};
      // Top bit of trial set means the subtraction went negative: restore.
      if (!trial[WIDTH]) begin
        step_hi = trial[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = shifted[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = iterative ? BUSY : DONE;
      BUSY:    if (cnt == LAST) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt    <= '0;
      OUT    <= '0;
      OUT_HI <= '0;
      Status <= 1'b0;
      Error  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q <= Operation;
        b_q  <= IN2;
        hi_q <= '0;
        lo_q <= IN1;
        cnt  <= '0;
        if (!iterative) begin
          OUT    <= sc_lo;
          OUT_HI <= sc_hi;
          Status <= (sc_lo == '0);
          Error  <= sc_err;
        end
      end else if (state == BUSY) begin
        hi_q <= step_hi;
        lo_q <= step_lo;
        if (cnt == LAST) begin
          OUT    <= step_lo;
          OUT_HI <= step_hi;
          Status <= (step_lo == '0);
          Error  <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_iterative.sv
// Self-checking bench for alu_iterative (WIDTH=32): directed cases plus random ops vs. an arithmetic model.
// Checks reset values, results, flags, latency, hold-under-backpressure and async abort.
// Every comparison is an immediate assertion; the summary line reports totals.
module tb_alu_iterative;

  localparam int W = 32;

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] IN1, IN2, OUT, OUT_HI;
  logic [3:0]   Operation;
  logic         Status, Error;

  int total = 0;
  int bad   = 0;

  alu_iterative #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .IN1(IN1), .IN2(IN2), .Operation(Operation),
    .out_valid(out_valid), .out_ready(out_ready),
    .OUT(OUT), .OUT_HI(OUT_HI), .Status(Status), .Error(Error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic straight from the opcode table.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] lo, output logic [W-1:0] hi,
                       output logic st, output logic er, output int lat);
    logic [2*W-1:0] p;
    lo = '0; hi = '0; er = 1'b0; lat = 1;
    case (op)
      4'd0: lo = a & b;
      4'd1: lo = a | b;
      4'd2: lo = a + b;
      4'd3: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        lo = p[W-1:0]; hi = p[2*W-1:W]; lat = W + 1;
      end
      4'd4: begin
        if (b == 0) begin
          lo = '1; hi = a; er = 1'b1;
        end else begin
          lo = a / b; hi = a % b; lat = W + 1;
        end
      end
      4'd5: lo = ~a;
      4'd6: lo = a - b;
      4'd7: lo = a >> (b % W);
      4'd8: lo = a << (b % W);
      default: er = 1'b1;
    endcase
    st = (lo == 0);
  endtask

  // Issue one op, poke in_valid while busy, hold out_ready low for 'hold' cycles, check everything.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [W-1:0] elo, ehi;
    logic est, eer;
    int elat, lat;
    model(op, a, b, elo, ehi, est, eer, elat);
    for (int i = 0; i < 50 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    check("ready_before", in_ready, 1'b1);
    in_valid = 1'b1; Operation = op; IN1 = a; IN2 = b;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    lat = 1;
    // Garbage request while busy: must be neither accepted nor disturb the latched operands.
    Operation = 4'($urandom_range(0, 15)); IN1 = $urandom; IN2 = $urandom;
    while (!out_valid && lat < 100) begin
      check("busy_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, elat);
    check("out_valid", out_valid, 1'b1);
    check("done_in_ready", in_ready, 1'b0);
    check("OUT", OUT, elo);
    check("OUT_HI", OUT_HI, ehi);
    check("Status", Status, est);
    check("Error", Error, eer);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1'b1);
      check("hold_OUT", OUT, elo);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("drop_valid", out_valid, 1'b0);
    check("back_idle", in_ready, 1'b1);
    check("idle_OUT_kept", OUT, elo);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    IN1 = '0; IN2 = '0; Operation = '0;
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_OUT", OUT, '0);
    check("rst_OUT_HI", OUT_HI, '0);
    check("rst_Status", Status, 1'b0);
    check("rst_Error", Error, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Directed steps.
    run_op(4'd2, 32'hFFFF_FFFF, 32'd1, 0);         // ADD wrap -> 0, Status=1
    run_op(4'd3, 32'h0001_0000, 32'h0001_0000, 0); // MUL -> hi=1, lo=0
    run_op(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); // MUL max*max
    run_op(4'd4, 32'd100, 32'd7, 0);               // DIV 14 r 2
    run_op(4'd4, 32'd5, 32'd0, 0);                 // DIV by zero
    run_op(4'd4, 32'hFFFF_FFFF, 32'd1, 0);         // DIV by one
    run_op(4'd6, 32'd3, 32'd5, 4);                 // SUB under backpressure
    run_op(4'd7, 32'h8000_0000, 32'd31, 0);        // RS
    run_op(4'd8, 32'h0000_0001, 32'd31, 0);        // LS
    run_op(4'd5, 32'h1234_5678, 32'd0, 0);         // NOT
    run_op(4'd12, 32'hDEAD_BEEF, 32'd9, 0);        // illegal opcode

    // Randomized ops against the model.
    for (int n = 0; n < 40; n++) begin
      logic [3:0] op;
      logic [W-1:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = 32'($urandom_range(1, 40));
        default: b = $urandom;
      endcase
      run_op(op, a, b, $urandom_range(0, 2));
    end

    // Async reset in the middle of a DIV aborts it.
    in_valid = 1'b1; Operation = 4'd4; IN1 = 32'd1000; IN2 = 32'd3; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_OUT", OUT, '0);
    check("abort_OUT_HI", OUT_HI, '0);
    check("abort_Status", Status, 1'b0);
    check("abort_Error", Error, 1'b0);
    @(negedge clk); rst = 1'b0; out_ready = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      check("abort_no_result", out_valid, 1'b0);
    end
    run_op(4'd0, 32'h0000_F0F0, 32'h0000_0FF0, 0); // AND -> 0x00F0

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
